imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage for the RV32/RV64 core decode path, placed between instruction fetch and the decode/execute register.
- Accepts one instruction per cycle over a valid/ready handshake.
- Produces the sign- or zero-extended immediate, a format code and an illegal flag, with a sideband tag carried alongside.
- Includes a 2-entry skid buffer so that `in_ready` is purely registered, plus a synchronous flush for redirects.

Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64. Controls the immediate width, the shamt width and the RV64-only opcodes.
- TAG_W, 32: width of the sideband tag (normally the PC), passed through unmodified.
- CSR_EN, 1: 1 enables decode of SYSTEM/CSR immediates. 0 makes every SYSTEM opcode illegal.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous; discards all held entries and any input presented in the same cycle.
- in_valid, input, 1: upstream has an instruction.
- in_ready, output, 1: stage can accept; registered.
- in_instr, input, 32: raw instruction.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: output entry valid.
- out_ready, input, 1: downstream accepts.
- out_imm, output, XLEN: generated immediate.
- out_fmt, output, 3: format code. 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRI.
- out_illegal, output, 1: encoding is illegal for this configuration.
- out_tag, output, TAG_W: tag matching the output entry.

Behaviour:
- Reset values (rst_n low, asynchronous): out_valid=0, skid entry empty, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- No transfer is counted while rst_n is low.
- Handshake:
  - Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
  - in_ready = !skid_valid; it is a flop output with no combinational path from out_ready.
  - On input fire, the decode result loads the output register if it is empty or firing this cycle. Otherwise it loads the skid register.
  - On output fire with skid valid, the skid entry moves to the output register in the same edge. If an input also fires that cycle, the input goes to skid.
  - Order is strictly FIFO. Latency is 1 cycle from input fire to out_valid when empty. Throughput is 1 per cycle.
  - Output fields are stable while out_valid=1 and out_ready=0.
- flush:
  - Clears out_valid and skid_valid on the next edge and ignores input fire that cycle.
  - in_ready is 1 on the following cycle.
  - flush has priority over every other event.
- Decode (opcode = instr[6:2]); all immediates are sign-extended from instr[31] to XLEN unless noted:
  - LOAD 00000 and JALR 11001: I format.
  - OP-IMM 00100:
    - funct3 001 or 101 gives SHAMT. The immediate is zero-extended instr[24:20] when XLEN=32, and instr[25:20] when XLEN=64.
    - With XLEN=32, instr[25]=1 on these shifts sets illegal.
    - All other funct3 values give I format.
  - OP-IMM-32 00110 (XLEN=64 only): funct3 001 or 101 gives SHAMT with instr[24:20]; otherwise I format. With XLEN=32 this opcode is illegal.
  - STORE 01000: S format, imm = {instr[31:25], instr[11:7]}.
  - BRANCH 11000: B format, imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - LUI 01101 and AUIPC 00101: U format, imm = {instr[31:12], 12'b0}; with XLEN=64 this is sign-extended from bit 31.
  - JAL 11011: J format, imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SYSTEM 11100 with CSR_EN=1:
    - funct3 101, 110 or 111 gives CSRI with imm = zero-extended instr[19:15].
    - funct3 000, 001, 010 or 011 gives NONE with imm=0.
    - funct3 100 is illegal.
  - OP 01100, MISC-MEM 00011, and OP-32 01110 (XLEN=64 only): NONE, imm=0, legal.
  - Any other opcode, or instr[1:0] != 2'b11: illegal.
- Whenever illegal=1, imm=0 and fmt=NONE. Every path assigns all outputs, so no latches are inferred.

Test Plan:
- XLEN=32, send 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → after 1 cycle: out_imm=0xFFFFFFFF, fmt=1, illegal=0, tag echoed. With XLEN=64 → out_imm=0xFFFFFFFF_FFFFFFFF.
- Immediate-format sweep:
  - 0x4030D093 (srai) → imm=3, fmt=6.
  - 0x123452B7 (lui) → imm=0x12345000, fmt=4.
  - 0xFFDFF06F (jal -4) → imm=0xFFFFFFFC, fmt=5.
  - 0x51E2D073 (csrrwi) → imm=5, fmt=7.
- Illegal encodings:
  - XLEN=32, 0x0200D093 (srli with shamt bit5 set) → illegal=1, imm=0.
  - 0x00000013 with bits[1:0] forced to 00 → illegal=1.
  - CSR_EN=0 with 0x51E2D073 → illegal=1.
- Backpressure: hold out_ready=0 and offer instructions A, B, C back-to-back → A and B accepted; in_ready=0 the cycle after B is accepted; C is held. Then raise out_ready → A, B, C emerge in order with no loss or duplication.
- Flush with both entries full while input is valid → next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears.
- Assert rst_n=0 asynchronously mid-stream → out_valid drops immediately without waiting for a clock edge. After release, the first new instruction appears with latency 1.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the RV32/RV64 immediate, format and
// legality of one instruction per cycle behind a 2-entry skid buffer with a registered in_ready.
module imm_gen_stage #(
  parameter int          XLEN   = 32,
  parameter int          TAG_W  = 32,
  parameter int unsigned CSR_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSRI  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [4:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            is_shift;
  entry_t          dec;

  assign opcode   = in_instr[6:2];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Size casts of signed operands sign-extend from instr[31] to XLEN.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    dec.tag = in_tag;
    case (opcode)
      5'b00000, 5'b11001: begin
        dec.imm = imm_i;
        dec.fmt = FMT_I;
      end
      5'b00100: begin
        if (is_shift) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            dec.imm = XLEN'(in_instr[25:20]);
          end else begin
            dec.imm = XLEN'(in_instr[24:20]);
            dec.ill = in_instr[25];
          end
        end else begin
          dec.imm = imm_i;
          dec.fmt = FMT_I;
        end
      end
      5'b00110: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec.imm = XLEN'(in_instr[24:20]);
            dec.fmt = FMT_SHAMT;
          end else begin
            dec.imm = imm_i;
            dec.fmt = FMT_I;
          end
        end else begin
          dec.ill = 1'b1;
        end
      end
      5'b01000: begin
        dec.imm = imm_s;
        dec.fmt = FMT_S;
      end
      5'b11000: begin
        dec.imm = imm_b;
        dec.fmt = FMT_B;
      end
      5'b01101, 5'b00101: begin
        dec.imm = imm_u;
        dec.fmt = FMT_U;
      end
      5'b11011: begin
        dec.imm = imm_j;
        dec.fmt = FMT_J;
      end
      5'b11100: begin
        if (CSR_EN == 0 || funct3 == 3'b100) begin
          dec.ill = 1'b1;
        end else if (funct3[2]) begin
          dec.imm = XLEN'(in_instr[19:15]);
          dec.fmt = FMT_CSRI;
        end
      end
      5'b01100, 5'b00011: ;
      5'b01110: dec.ill = (XLEN != 64);
      default:  dec.ill = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) begin
      dec.ill = 1'b1;
    end
    if (dec.ill) begin
      dec.imm = '0;
      dec.fmt = FMT_NONE;
    end
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  logic   in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      // Output slot frees up: skid entry is older, so it goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_d = dec;
        end
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.ill;
  assign out_tag     = out_q.tag;

endmodule
